stall_ctrl: RTL and testbench



---
 rtl/stall_ctrl_pkg.sv | 36 +++
 rtl/ctrl_inst_hold.sv | 38 +++
 rtl/stall_ctrl.sv | 99 +++++++++
 tb/tb_stall_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package stall_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    // Stall bus: bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam stall_bus_t STALL_NONE    = 6'b000000;
    localparam stall_bus_t STALL_LOADUSE = 6'b000111;
    localparam stall_bus_t STALL_EX      = 6'b001111;

    // Index of the ID stage bit; it also drives the instruction hold
    localparam int STALL_BIT_ID = 2;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_DIV = 1'b1
    } ctrl_state_t;

    // Stall pattern while running: a divide entering EX outranks load-use
    function automatic stall_bus_t run_stall(input logic div_start, input logic load_use);
        stall_bus_t result;
        result = STALL_NONE;
        if (div_start) begin
            result = STALL_EX;
        end else if (load_use) begin
            result = STALL_LOADUSE;
        end
        return result;
    endfunction

endpackage

// File: rtl/ctrl_inst_hold.sv
// Holds the fetched instruction stable for ID while ID is frozen.
module ctrl_inst_hold
    import stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        hold_en,
    input  logic [31:0] inst_in,
    output logic [31:0] inst_out
);

    logic        hold_valid_reg;
    logic [31:0] hold_inst_reg;

    // Capture on the first frozen edge only; drop the hold once ID moves again
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_valid_reg <= 1'b0;
            hold_inst_reg  <= '0;
        end else if (hold_en == STOP) begin
            if (!hold_valid_reg) begin
                hold_inst_reg  <= inst_in;
                hold_valid_reg <= 1'b1;
            end
        end else begin
            hold_valid_reg <= 1'b0;
        end
    end

    // Byte-wise output select between the held and the live instruction
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mux
            assign inst_out[gi*8 +: 8] = hold_valid_reg ? hold_inst_reg[gi*8 +: 8]
                                                        : inst_in[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: merges load-use and multi-cycle divide stalls,
// guards the divider with a timeout and counts stalled cycles.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int STALL_W     = 6,
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_for_id,
    input  logic               ex_div_start,
    input  logic               div_ready,
    input  logic [31:0]        inst_sram_rdata,
    output logic [STALL_W-1:0] stall,
    output logic [31:0]        id_inst,
    output logic               div_busy,
    output logic               div_timeout,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int DIV_CNT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_TIMEOUT - 1);

    ctrl_state_t          state_reg;
    logic [DIV_CNT_W-1:0] div_cnt_reg;
    logic                 div_timeout_reg;
    logic [CNT_W-1:0]     stall_cnt_reg;
    stall_bus_t           stall_next;
    logic                 div_expire;

    // Stall vector is purely combinational so hazards freeze the pipe in the same cycle
    always_comb begin
        stall_next = STALL_NONE;
        if (resetn) begin
            case (state_reg)
                ST_RUN:  stall_next = run_stall(ex_div_start, stallreq_for_id);
                ST_DIV:  stall_next = div_ready ? STALL_NONE : STALL_EX;
                default: stall_next = STALL_NONE;
            endcase
        end
    end

    // Last allowed DIV cycle with no result: leave DIV and flag the timeout
    assign div_expire = (state_reg == ST_DIV) && !div_ready && (div_cnt_reg == DIV_LAST);

    // Divide FSM with its occupancy counter and sticky timeout flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_RUN;
            div_cnt_reg     <= '0;
            div_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (ex_div_start) begin
                        state_reg   <= ST_DIV;
                        div_cnt_reg <= '0;
                    end
                end
                ST_DIV: begin
                    if (div_ready) begin
                        state_reg <= ST_RUN;
                    end else if (div_expire) begin
                        state_reg       <= ST_RUN;
                        div_timeout_reg <= 1'b1;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    // Saturating count of cycles in which any stage is stopped
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_reg <= '0;
        end else if ((stall_next != STALL_NONE) && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    ctrl_inst_hold u_inst_hold (
        .clk      (clk),
        .resetn   (resetn),
        .hold_en  (stall_next[STALL_BIT_ID]),
        .inst_in  (inst_sram_rdata),
        .inst_out (id_inst)
    );

    assign stall       = STALL_W'(stall_next);
    assign div_busy    = (state_reg == ST_DIV);
    assign div_timeout = div_timeout_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl; a narrow counter makes saturation reachable.
module tb_stall_ctrl;

    localparam int CNT_W = 6;

    logic             clk;
    logic             resetn;
    logic             stallreq_for_id;
    logic             ex_div_start;
    logic             div_ready;
    logic [31:0]      inst_sram_rdata;
    logic [5:0]       stall;
    logic [31:0]      id_inst;
    logic             div_busy;
    logic             div_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks;
    int n_fail;

    stall_ctrl #(
        .STALL_W     (6),
        .DIV_TIMEOUT (64),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stallreq_for_id (stallreq_for_id),
        .ex_div_start    (ex_div_start),
        .div_ready       (div_ready),
        .inst_sram_rdata (inst_sram_rdata),
        .stall           (stall),
        .id_inst         (id_inst),
        .div_busy        (div_busy),
        .div_timeout     (div_timeout),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", tag, obs, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_for_id = 1'b0;
        ex_div_start    = 1'b0;
        div_ready       = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset state: requests active but reset forces stall low
        resetn          = 1'b0;
        stallreq_for_id = 1'b1;
        ex_div_start    = 1'b1;
        div_ready       = 1'b0;
        inst_sram_rdata = 32'hCAFEF00D;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_stall", 64'(stall), 64'h00);
        check_eq("rst_busy", 64'(div_busy), 64'h0);
        check_eq("rst_timeout", 64'(div_timeout), 64'h0);
        check_eq("rst_cnt", 64'(stall_cnt), 64'h0);
        check_eq("rst_id_inst", 64'(id_inst), 64'hCAFEF00D);
        idle_inputs();
        next_cycle();
        resetn = 1'b1;

        // Load-use: one bubble, instruction held for ID across it
        stallreq_for_id = 1'b1;
        inst_sram_rdata = 32'h8C410004;
        @(negedge clk);
        check_eq("lu_stall", 64'(stall), 64'h07);
        check_eq("lu_id_inst0", 64'(id_inst), 64'h8C410004);
        next_cycle();
        stallreq_for_id = 1'b0;
        inst_sram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("lu_stall_off", 64'(stall), 64'h00);
        check_eq("lu_id_inst1", 64'(id_inst), 64'h8C410004);
        check_eq("lu_cnt", 64'(stall_cnt), 64'd1);
        next_cycle();
        @(negedge clk);
        check_eq("lu_id_live", 64'(id_inst), 64'hDEADBEEF);
        check_eq("lu_cnt_hold", 64'(stall_cnt), 64'd1);

        // Divide with ready 33 cycles after start
        do_reset();
        ex_div_start    = 1'b1;
        inst_sram_rdata = 32'h0062001A;
        @(negedge clk);
        check_eq("div_stall_entry", 64'(stall), 64'h0F);
        check_eq("div_busy_entry", 64'(div_busy), 64'h0);
        for (int i = 1; i <= 32; i++) begin
            next_cycle();
            @(negedge clk);
            check_eq($sformatf("div_stall_c%0d", i), 64'(stall), 64'h0F);
            check_eq($sformatf("div_busy_c%0d", i), 64'(div_busy), 64'h1);
        end
        next_cycle();
        div_ready = 1'b1;
        @(negedge clk);
        check_eq("div_stall_ready", 64'(stall), 64'h00);
        check_eq("div_busy_ready", 64'(div_busy), 64'h1);
        next_cycle();
        div_ready    = 1'b0;
        ex_div_start = 1'b0;
        @(negedge clk);
        check_eq("div_busy_after", 64'(div_busy), 64'h0);
        check_eq("div_stall_after", 64'(stall), 64'h00);
        check_eq("div_cnt", 64'(stall_cnt), 64'd33);

        // Divide and load-use together: divide wins, load-use follows
        do_reset();
        ex_div_start    = 1'b1;
        stallreq_for_id = 1'b1;
        inst_sram_rdata = 32'h11111111;
        @(negedge clk);
        check_eq("mix_stall_entry", 64'(stall), 64'h0F);
        check_eq("mix_id_entry", 64'(id_inst), 64'h11111111);
        next_cycle();
        inst_sram_rdata = 32'h22222222;
        @(negedge clk);
        check_eq("mix_stall_div", 64'(stall), 64'h0F);
        check_eq("mix_id_held", 64'(id_inst), 64'h11111111);
        next_cycle();
        @(negedge clk);
        check_eq("mix_stall_div2", 64'(stall), 64'h0F);
        next_cycle();
        div_ready = 1'b1;
        @(negedge clk);
        check_eq("mix_stall_ready", 64'(stall), 64'h00);
        check_eq("mix_id_ready", 64'(id_inst), 64'h11111111);
        next_cycle();
        div_ready    = 1'b0;
        ex_div_start = 1'b0;
        @(negedge clk);
        check_eq("mix_stall_lu", 64'(stall), 64'h07);
        check_eq("mix_busy_lu", 64'(div_busy), 64'h0);
        check_eq("mix_id_live", 64'(id_inst), 64'h22222222);
        next_cycle();
        stallreq_for_id = 1'b0;
        inst_sram_rdata = 32'h33333333;
        @(negedge clk);
        check_eq("mix_stall_end", 64'(stall), 64'h00);
        check_eq("mix_id_held2", 64'(id_inst), 64'h22222222);
        check_eq("mix_cnt", 64'(stall_cnt), 64'd4);

        // Divide timeout: 65 stalled cycles, sticky flag, counter saturates
        do_reset();
        ex_div_start = 1'b1;
        @(negedge clk);
        check_eq("to_stall_entry", 64'(stall), 64'h0F);
        for (int i = 1; i <= 64; i++) begin
            next_cycle();
            @(negedge clk);
            check_eq($sformatf("to_stall_c%0d", i), 64'(stall), 64'h0F);
            check_eq($sformatf("to_flag_c%0d", i), 64'(div_timeout), 64'h0);
        end
        next_cycle();
        ex_div_start = 1'b0;
        @(negedge clk);
        check_eq("to_stall_rel", 64'(stall), 64'h00);
        check_eq("to_busy_rel", 64'(div_busy), 64'h0);
        check_eq("to_flag_set", 64'(div_timeout), 64'h1);
        check_eq("to_cnt_sat", 64'(stall_cnt), 64'h3F);
        next_cycle();
        div_ready = 1'b1;
        @(negedge clk);
        check_eq("to_late_ready_stall", 64'(stall), 64'h00);
        next_cycle();
        div_ready = 1'b0;
        @(negedge clk);
        check_eq("to_late_ready_busy", 64'(div_busy), 64'h0);
        check_eq("to_flag_sticky", 64'(div_timeout), 64'h1);
        next_cycle();
        stallreq_for_id = 1'b1;
        @(negedge clk);
        check_eq("sat_stall", 64'(stall), 64'h07);
        next_cycle();
        stallreq_for_id = 1'b0;
        @(negedge clk);
        check_eq("sat_cnt_hold", 64'(stall_cnt), 64'h3F);
        check_eq("sat_flag_sticky", 64'(div_timeout), 64'h1);

        // Reset asserted in cycle 5 of a divide
        do_reset();
        ex_div_start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
        end
        @(negedge clk);
        check_eq("mid_busy_pre", 64'(div_busy), 64'h1);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("mid_rst_stall", 64'(stall), 64'h00);
        check_eq("mid_rst_busy", 64'(div_busy), 64'h0);
        check_eq("mid_rst_flag", 64'(div_timeout), 64'h0);
        check_eq("mid_rst_cnt", 64'(stall_cnt), 64'h0);
        ex_div_start = 1'b0;
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_stall", 64'(stall), 64'h00);
        check_eq("mid_rel_busy", 64'(div_busy), 64'h0);
        check_eq("mid_rel_flag", 64'(div_timeout), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
